march_cminus_sequencer: RTL and testbench

- March C- test sequencer for the single-port SRAM under MBIST.
- Replaces the free-running counter/decoder pattern path with an explicit element/operation state machine.
- Drives memory address, write data and write enable in test mode, and compares read data against expected values through a read-latency-matched pipeline.
- Records a sticky fail flag, the first failing address/element, and a saturating fail count for the top-level fail logic.

---
 rtl/march_cminus_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_march_cminus_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/march_cminus_sequencer.sv
`default_nettype none
// ============================================================================
// march_cminus_sequencer : March C- MBIST sequencer with read-latency-matched
// compare and first-fail capture.                      Revision 1.0
// ============================================================================
module march_cminus_sequencer #(
  parameter int WCOUNT  = 256,
  parameter int WLENGTH = 4,
  parameter int RD_LAT  = 1,
  parameter int FCNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WLENGTH-1:0]        mem_dout,
  output logic                      tmode,
  output logic [$clog2(WCOUNT)-1:0] mem_addr,
  output logic [WLENGTH-1:0]        mem_din,
  output logic                      mem_we,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [$clog2(WCOUNT)-1:0] fail_addr,
  output logic [2:0]                fail_elem,
  output logic [FCNT_W-1:0]         fail_count
);

  localparam int AW = $clog2(WCOUNT);
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0]    LAST_ELEM = 3'd5;
  localparam logic [AW-1:0] ADDR_MAX  = AW'(WCOUNT - 1);
  localparam logic [DW-1:0] DRAIN_END = DW'(RD_LAT - 1);

  // Element table: E0 w0 | E1 r0,w1 | E2 r1,w0 | E3 r0,w1 | E4 r1,w0 | E5 r0
  function automatic logic op_is_write(input logic [2:0] e, input logic o);
    case (e)
      3'd0:    return 1'b1;
      3'd5:    return 1'b0;
      default: return o;
    endcase
  endfunction

  function automatic logic op_value(input logic [2:0] e, input logic o);
    case (e)
      3'd1, 3'd3: return o;
      3'd2, 3'd4: return ~o;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic elem_last_op(input logic [2:0] e, input logic o);
    return (e == 3'd0 || e == 3'd5) ? 1'b1 : o;
  endfunction

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3 || e == 3'd4);
  endfunction

  typedef struct packed {
    logic               v;
    logic [WLENGTH-1:0] exp;
    logic [AW-1:0]      addr;
    logic [2:0]         elem;
  } cmp_t;

  logic [1:0]    state, state_nxt;
  logic [2:0]    elem, n_elem;
  logic          op, n_op;
  logic [AW-1:0] addr, n_addr;
  logic          we_q, din_bit, rd_valid;
  logic [DW-1:0] drain_cnt;
  logic          addr_end, run_end;
  logic          n_we;
  cmp_t          pipe [RD_LAT];
  cmp_t          head;
  logic          mismatch;

  assign addr_end = elem_down(elem) ? (addr == '0) : (addr == ADDR_MAX);

  // Successor of the op currently on the bus.
  always_comb begin
    n_elem  = elem;
    n_op    = op;
    n_addr  = addr;
    run_end = 1'b0;
    if (!elem_last_op(elem, op)) begin
      n_op = 1'b1;
    end else begin
      n_op = 1'b0;
      if (!addr_end) begin
        n_addr = elem_down(elem) ? addr - 1'b1 : addr + 1'b1;
      end else if (elem == LAST_ELEM) begin
        run_end = 1'b1;
      end else begin
        n_elem = 3'(elem + 3'd1);
        n_addr = elem_down(n_elem) ? ADDR_MAX : '0;
      end
    end
  end

  assign n_we = op_is_write(n_elem, n_op);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (run_end) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == DRAIN_END) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tmode = (state == S_RUN) || (state == S_DRAIN);
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
  end

  // Bus registers always hold the op being executed this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      elem      <= '0;
      op        <= 1'b0;
      addr      <= '0;
      we_q      <= 1'b0;
      din_bit   <= 1'b0;
      rd_valid  <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            elem     <= '0;
            op       <= 1'b0;
            addr     <= '0;
            we_q     <= 1'b1;
            din_bit  <= 1'b0;
            rd_valid <= 1'b0;
          end
        end
        S_RUN: begin
          drain_cnt <= '0;
          if (run_end) begin
            we_q     <= 1'b0;
            rd_valid <= 1'b0;
          end else begin
            elem     <= n_elem;
            op       <= n_op;
            addr     <= n_addr;
            we_q     <= n_we;
            din_bit  <= op_value(n_elem, n_op);
            rd_valid <= ~n_we;
          end
        end
        S_DRAIN: drain_cnt <= drain_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_addr = addr;
  assign mem_we   = we_q;
  assign mem_din  = {WLENGTH{din_bit}};

  // Read metadata travels alongside the RAM's own latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0].v    <= rd_valid;
      pipe[0].exp  <= mem_din;
      pipe[0].addr <= addr;
      pipe[0].elem <= elem;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign head     = pipe[RD_LAT-1];
  assign mismatch = head.v && (mem_dout != head.exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_count <= '0;
    end else if (state == S_IDLE && start) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_count <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (fail_count != '1) fail_count <= fail_count + 1'b1;
      if (!fail) begin
        fail_addr <= head.addr;
        fail_elem <= head.elem;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_march_cminus_sequencer.sv
`default_nettype none
// Directed bench for march_cminus_sequencer: two 16-word instances (read latency
// 1 and 3) against behavioural RAMs with injectable stuck-at bits.
module tb_march_cminus_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;

  logic       tmode_a, mem_we_a, busy_a, done_a, fail_a;
  logic [3:0] mem_addr_a, mem_din_a, mem_dout_a, fail_addr_a;
  logic [2:0] fail_elem_a;
  logic [7:0] fail_count_a;

  logic       tmode_b, mem_we_b, busy_b, done_b, fail_b;
  logic [3:0] mem_addr_b, mem_din_b, mem_dout_b, fail_addr_b;
  logic [2:0] fail_elem_b;
  logic [1:0] fail_count_b;

  logic [3:0] fa = '0, s1 = '0, s0 = '0;

  always #5 clk = ~clk;

  march_cminus_sequencer #(.WCOUNT(16), .WLENGTH(4), .RD_LAT(1), .FCNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mem_dout(mem_dout_a),
    .tmode(tmode_a), .mem_addr(mem_addr_a), .mem_din(mem_din_a), .mem_we(mem_we_a),
    .busy(busy_a), .done(done_a), .fail(fail_a), .fail_addr(fail_addr_a),
    .fail_elem(fail_elem_a), .fail_count(fail_count_a));

  march_cminus_sequencer #(.WCOUNT(16), .WLENGTH(4), .RD_LAT(3), .FCNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mem_dout(mem_dout_b),
    .tmode(tmode_b), .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_we(mem_we_b),
    .busy(busy_b), .done(done_b), .fail(fail_b), .fail_addr(fail_addr_b),
    .fail_elem(fail_elem_b), .fail_count(fail_count_b));

  function automatic logic [3:0] flt(input logic [3:0] d, input logic hit);
    return hit ? ((d | s1) & ~s0) : d;
  endfunction

  logic [3:0] ram_a [16];
  logic [3:0] q_a = '0;
  always @(posedge clk) begin
    q_a <= flt(ram_a[mem_addr_a], mem_addr_a == fa);
    if (mem_we_a) ram_a[mem_addr_a] <= mem_din_a;
  end
  assign mem_dout_a = q_a;

  logic [3:0] ram_b [16];
  logic [3:0] q_b0 = '0, q_b1 = '0, q_b2 = '0;
  always @(posedge clk) begin
    q_b0 <= flt(ram_b[mem_addr_b], mem_addr_b == fa);
    q_b1 <= q_b0;
    q_b2 <= q_b1;
    if (mem_we_b) ram_b[mem_addr_b] <= mem_din_b;
  end
  assign mem_dout_b = q_b2;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bus trace of the latest A run, indexed by cycle after the start edge.
  logic [3:0] log_addr [402];
  logic       log_we   [402];
  logic [3:0] log_din  [402];
  logic [3:0] ex_addr  [402];
  logic       ex_we    [402];
  logic [3:0] ex_din   [402];

  task automatic build_expected();
    int idx = 1;
    int nops [6]   = '{1, 2, 2, 2, 2, 1};
    bit [1:0] wem [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    bit [1:0] vm  [6] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 16; i++) begin
        for (int o = 0; o < nops[e]; o++) begin
          ex_addr[idx] = (e == 3 || e == 4) ? 4'(15 - i) : 4'(i);
          ex_we[idx]   = wem[e][o];
          ex_din[idx]  = vm[e][o] ? 4'hF : 4'h0;
          idx++;
        end
      end
    end
  endtask

  task automatic run(input bit sel_b, input int restart_at, output int dcyc);
    dcyc = -1;
    @(negedge clk);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      if (!sel_b) begin
        log_addr[n] = mem_addr_a;
        log_we[n]   = mem_we_a;
        log_din[n]  = mem_din_a;
      end
      if (sel_b ? done_b : done_a) begin
        dcyc = n;
        break;
      end
      start_a = (!sel_b && n == restart_at);
      @(negedge clk);
    end
    start_a = 1'b0;
  endtask

  task automatic check_trace(input string name);
    int bad_at = 0;
    for (int c = 1; c <= 160; c++)
      if (bad_at == 0 && (log_addr[c] != ex_addr[c] || log_we[c] != ex_we[c] ||
                          (ex_we[c] && log_din[c] != ex_din[c])))
        bad_at = c;
    if (bad_at == 0 && log_we[161] != 1'b0) bad_at = 161;
    check(name, bad_at, 0);
  endtask

  typedef struct {
    bit         lat3;
    logic [3:0] fa, s1, s0;
    int         dcyc;
    bit         fail;
    logic [3:0] faddr;
    logic [2:0] felem;
    int         fcnt;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int d;
    vecs[0] = '{0, 4'd0,  4'h0, 4'h0, 162, 1'b0, 4'd0,  3'd0, 0};
    vecs[1] = '{0, 4'd5,  4'h1, 4'h0, 162, 1'b1, 4'd5,  3'd1, 3};
    vecs[2] = '{0, 4'd0,  4'h0, 4'h4, 162, 1'b1, 4'd0,  3'd2, 2};
    vecs[3] = '{0, 4'd10, 4'h8, 4'h1, 162, 1'b1, 4'd10, 3'd1, 5};
    vecs[4] = '{1, 4'd0,  4'h0, 4'h0, 164, 1'b0, 4'd0,  3'd0, 0};
    vecs[5] = '{1, 4'd15, 4'h0, 4'h8, 164, 1'b1, 4'd15, 3'd2, 2};
    vecs[6] = '{1, 4'd10, 4'h8, 4'h1, 164, 1'b1, 4'd10, 3'd1, 3};
    build_expected();

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tmode", int'(tmode_a), 0);
    check("rst_we", int'(mem_we_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_fail", int'(fail_a), 0);
    check("rst_fcnt", int'(fail_count_a), 0);
    check("rst_addr", int'(mem_addr_a), 0);
    check("rst_b_busy_tmode", int'({busy_b, tmode_b}), 0);

    for (int i = 0; i < 7; i++) begin
      fa = vecs[i].fa;
      s1 = vecs[i].s1;
      s0 = vecs[i].s0;
      run(vecs[i].lat3, 0, d);
      check($sformatf("v%0d_done_cycle", i), d, vecs[i].dcyc);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), int'(vecs[i].lat3 ? done_b : done_a), 0);
      check($sformatf("v%0d_fail", i), int'(vecs[i].lat3 ? fail_b : fail_a), int'(vecs[i].fail));
      check($sformatf("v%0d_fail_addr", i), int'(vecs[i].lat3 ? fail_addr_b : fail_addr_a),
            int'(vecs[i].faddr));
      check($sformatf("v%0d_fail_elem", i), int'(vecs[i].lat3 ? fail_elem_b : fail_elem_a),
            int'(vecs[i].felem));
      check($sformatf("v%0d_fail_count", i),
            vecs[i].lat3 ? int'(fail_count_b) : int'(fail_count_a), vecs[i].fcnt);
      if (!vecs[i].lat3 && vecs[i].s1 == 4'h0 && vecs[i].s0 == 4'h0) begin
        check_trace("trace_fault_free");
        check("first_op", int'({log_we[1], log_addr[1], log_din[1]}), int'({1'b1, 4'd0, 4'h0}));
        check("e3_op0", int'({log_we[81], log_addr[81], log_din[81]}), int'({1'b0, 4'd15, 4'h0}));
        check("e3_op1", int'({log_we[82], log_addr[82], log_din[82]}), int'({1'b1, 4'd15, 4'hF}));
        check("e3_op2", int'({log_we[83], log_addr[83]}), int'({1'b0, 4'd14}));
        check("e5_op0", int'({log_we[145], log_addr[145], log_din[145]}), int'({1'b0, 4'd0, 4'h0}));
      end
    end

    // start re-pulsed mid-run must not disturb the sequence
    fa = '0; s1 = '0; s0 = '0;
    run(1'b0, 50, d);
    check("restart_done_cycle", d, 162);
    check_trace("trace_restart_ignored");

    // reset in the middle of E2 with a latched failure
    fa = 4'd5; s1 = 4'h1; s0 = 4'h0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (59) @(negedge clk);
    check("pre_rst_fail", int'(fail_a), 1);
    check("pre_rst_tmode", int'(tmode_a), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_tmode", int'(tmode_a), 0);
    check("mid_rst_we", int'(mem_we_a), 0);
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_fail", int'(fail_a), 0);
    check("mid_rst_fcnt", int'(fail_count_a), 0);
    fa = '0; s1 = '0;
    run(1'b0, 0, d);
    check("post_rst_done_cycle", d, 162);
    check("post_rst_fail", int'(fail_a), 0);
    check_trace("trace_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
